// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// State encoding, matrix geometry and the row-drive decode used by the scan FSM.
package keypad_pkg;

  typedef enum logic [2:0] {
    ROW0 = 3'd0,
    ROW1 = 3'd1,
    ROW2 = 3'd2,
    ROW3 = 3'd3,
    EVAL = 3'd4
  } kp_state_t;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam logic [KP_ROWS*KP_COLS-1:0] KP_NO_KEY = 16'h0000;

  // Active-low drive: exactly one row low while scanning, all high in EVAL.
  function automatic logic [KP_ROWS-1:0] row_drive(input kp_state_t s);
    logic [KP_ROWS-1:0] r;
    r = 4'b1111;
    case (s)
      ROW0:    r = 4'b1110;
      ROW1:    r = 4'b1101;
      ROW2:    r = 4'b1011;
      ROW3:    r = 4'b0111;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones (idle pull-up level).
// Latency 2 cycles, no backpressure.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with frame-level debounce; outputs a held one-hot key code.
// Output latency DEBOUNCE_FRAMES..DEBOUNCE_FRAMES+1 frames plus 2 sync cycles; no backpressure.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 50_000,
  parameter int DEBOUNCE_FRAMES = 20
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [15:0] onehot,
  output logic        key_strobe
);

  localparam int SCW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int STW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SCW-1:0] SLOT_LAST  = SCW'(SCAN_CYCLES - 1);
  localparam logic [STW-1:0] STABLE_MAX = STW'(DEBOUNCE_FRAMES);
  localparam int NKEYS = KP_ROWS * KP_COLS;

  kp_state_t            state_q, state_d;
  logic [SCW-1:0]       slot_cnt_q, slot_cnt_d;
  logic [NKEYS-1:0]     frame_q, frame_d;
  logic [NKEYS-1:0]     last_cand_q, last_cand_d;
  logic [STW-1:0]       stable_cnt_q, stable_cnt_d;
  logic [NKEYS-1:0]     onehot_q, onehot_d;
  logic                 key_strobe_q, key_strobe_d;
  logic [KP_ROWS-1:0]   row_q, row_d;

  logic [KP_COLS-1:0]   col_sync;
  logic [NKEYS-1:0]     cand;
  logic [STW-1:0]       stable_next;
  logic [1:0]           row_idx;

  sync2 #(.WIDTH(KP_COLS)) u_col_sync (
    .core_clk (clk),
    .arst_n   (RSTn),
    .d        (col),
    .q        (col_sync)
  );

  // Ghosting and multi-key presses both collapse to "no key".
  function automatic logic one_bit_set(input logic [NKEYS-1:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

  always_comb begin
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q;
    frame_d      = frame_q;
    last_cand_d  = last_cand_q;
    stable_cnt_d = stable_cnt_q;
    onehot_d     = onehot_q;
    key_strobe_d = 1'b0;
    cand         = KP_NO_KEY;
    stable_next  = stable_cnt_q;
    row_idx      = 2'd0;

    case (state_q)
      ROW1:    row_idx = 2'd1;
      ROW2:    row_idx = 2'd2;
      ROW3:    row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase

    case (state_q)
      ROW0, ROW1, ROW2, ROW3: begin
        if (slot_cnt_q == SLOT_LAST) begin
          frame_d[row_idx*KP_COLS +: KP_COLS] = ~col_sync;
          slot_cnt_d = '0;
          case (state_q)
            ROW0:    state_d = ROW1;
            ROW1:    state_d = ROW2;
            ROW2:    state_d = ROW3;
            default: state_d = EVAL;
          endcase
        end else begin
          slot_cnt_d = slot_cnt_q + 1'b1;
        end
      end
      EVAL: begin
        cand = one_bit_set(frame_q) ? frame_q : KP_NO_KEY;
        if (cand == last_cand_q) begin
          stable_next = (stable_cnt_q == STABLE_MAX) ? STABLE_MAX : stable_cnt_q + 1'b1;
        end else begin
          last_cand_d = cand;
          stable_next = STW'(1);
        end
        stable_cnt_d = stable_next;
        if (stable_next == STABLE_MAX && cand != onehot_q) begin
          onehot_d     = cand;
          key_strobe_d = (cand != KP_NO_KEY);
        end
        frame_d = '0;
        state_d = ROW0;
      end
      default: state_d = ROW0;
    endcase

    // Registered row drive tracks the state being entered.
    row_d = row_drive(state_d);
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= ROW0;
      slot_cnt_q   <= '0;
      frame_q      <= '0;
      last_cand_q  <= '0;
      stable_cnt_q <= '0;
      onehot_q     <= '0;
      key_strobe_q <= 1'b0;
      row_q        <= 4'b1110;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      frame_q      <= frame_d;
      last_cand_q  <= last_cand_d;
      stable_cnt_q <= stable_cnt_d;
      onehot_q     <= onehot_d;
      key_strobe_q <= key_strobe_d;
      row_q        <= row_d;
    end
  end

  assign row        = row_q;
  assign onehot     = onehot_q;
  assign key_strobe = key_strobe_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a physical keypad model drives col from row, and a frame-level
// debounce model (window of the last DEBOUNCE_FRAMES candidates) predicts onehot/key_strobe.
module tb_keypad_scan;

  localparam int SC    = 4;
  localparam int DF    = 3;
  localparam int FRAME = 4 * SC + 1;

  logic        clk;
  logic        RSTn;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] onehot;
  logic        key_strobe;

  logic [15:0] keys;

  int total = 0;
  int bad   = 0;

  logic [15:0] hist[$];
  logic [15:0] m_onehot;
  int          exp_strobe;

  keypad_scan #(.SCAN_CYCLES(SC), .DEBOUNCE_FRAMES(DF)) dut (
    .clk        (clk),
    .RSTn       (RSTn),
    .col        (col),
    .row        (row),
    .onehot     (onehot),
    .key_strobe (key_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key shorts its column low whenever its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cand_of(input logic [15:0] k);
    return ($countones(k) == 1) ? k : 16'h0000;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_onehot   = 16'h0000;
    exp_strobe = 0;
  endtask

  // Output moves to a candidate once the last DF frames all agreed on it.
  task automatic model_step(input logic [15:0] c);
    bit same;
    hist.push_back(c);
    if (hist.size() > DF) void'(hist.pop_front());
    exp_strobe = 0;
    if (hist.size() == DF) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != c) same = 1'b0;
      if (same && c != m_onehot) begin
        m_onehot   = c;
        exp_strobe = (c != 16'h0000) ? 1 : 0;
      end
    end
  endtask

  // Runs one full frame from just before its first edge; keys held throughout.
  task automatic run_frame(input string tag, input logic [15:0] k, input bit bounce, input int fidx);
    int strobes;
    int row_err;
    int j;
    int cyc;
    logic [3:0] exp_row;
    logic [15:0] c;
    strobes = 0;
    row_err = 0;
    keys = k;
    for (int e = 1; e <= FRAME; e++) begin
      if (bounce) begin
        cyc  = fidx * FRAME + e - 1;
        keys = (((cyc / 5) % 2) == 1) ? 16'h0040 : 16'h0000;
      end
      @(posedge clk);
      #1;
      j = e % FRAME;
      exp_row = (j < 4 * SC) ? (4'hF ^ (4'h1 << (j / SC))) : 4'hF;
      if (row !== exp_row) row_err++;
      if (key_strobe === 1'b1) strobes++;
    end
    if (bounce) begin
      // Row 1 is captured from col as seen 2 cycles before the end of its slot.
      cyc = fidx * FRAME + SC + SC - 3;
      c   = (((cyc / 5) % 2) == 1) ? 16'h0040 : 16'h0000;
    end else begin
      c = cand_of(k);
    end
    model_step(c);
    check({tag, "_row"}, row_err, 0);
    check({tag, "_onehot"}, onehot, m_onehot);
    check({tag, "_strobe"}, strobes, exp_strobe);
  endtask

  initial begin
    logic [15:0] k;
    int sel;
    int hold;

    keys = 16'h0000;
    RSTn = 1'b0;
    model_reset();

    // Reset and idle scan
    repeat (3) @(posedge clk);
    #1;
    check("rst_onehot", onehot, 16'h0000);
    check("rst_strobe", key_strobe, 1'b0);
    check("rst_row", row, 4'b1110);
    @(negedge clk);
    RSTn = 1'b1;
    for (int f = 0; f < 2; f++) run_frame("idle", 16'h0000, 1'b0, 0);

    // Single press of key 6, then release
    for (int f = 0; f < 5; f++) run_frame("press6", 16'h0040, 1'b0, 0);
    for (int f = 0; f < 4; f++) run_frame("release6", 16'h0000, 1'b0, 0);

    // Bounce, then steady hold
    for (int f = 0; f < 2; f++) run_frame("bounce", 16'h0000, 1'b1, f);
    for (int f = 0; f < 4; f++) run_frame("steady6", 16'h0040, 1'b0, 0);
    check("steady6_held", onehot, 16'h0040);

    // Reset mid-press with key still held
    keys = 16'h0040;
    repeat (7) @(posedge clk);
    #1;
    RSTn = 1'b0;
    #1;
    check("midrst_onehot", onehot, 16'h0000);
    check("midrst_row", row, 4'b1110);
    check("midrst_strobe", key_strobe, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    RSTn = 1'b1;
    for (int f = 0; f < 4; f++) run_frame("after_rst", 16'h0040, 1'b0, 0);
    for (int f = 0; f < 3; f++) run_frame("release_b", 16'h0000, 1'b0, 0);

    // Multi-key press: keys 0 and 5
    for (int f = 0; f < 6; f++) run_frame("multi", 16'h0021, 1'b0, 0);
    check("multi_zero", onehot, 16'h0000);

    // Key-to-key change 3 -> 15 without release
    for (int f = 0; f < 4; f++) run_frame("key3", 16'h0008, 1'b0, 0);
    for (int f = 0; f < 4; f++) run_frame("key15", 16'h8000, 1'b0, 0);
    check("key15_final", onehot, 16'h8000);

    // Random segments: none, single key or two keys, held for 1..5 frames
    for (int s = 0; s < 40; s++) begin
      sel = $urandom_range(0, 3);
      k = 16'h0000;
      if (sel == 1 || sel == 2) k[$urandom_range(0, 15)] = 1'b1;
      if (sel == 3) begin
        k[$urandom_range(0, 15)] = 1'b1;
        k[$urandom_range(0, 15)] = 1'b1;
      end
      hold = $urandom_range(1, 5);
      for (int f = 0; f < hold; f++) run_frame("rand", k, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

- Scans a 4x4 active-low matrix keypad and debounces it.
- Output is a one-hot key code: `onehot[15:0]`, where bit `r*4+c` is row r, column c.
- Output is held while exactly one key is stably pressed and is `16'h0000` otherwise.
- Sits directly upstream of the one-hot-to-digit encoder and drives its `onehot` input. Its hold-while-pressed, zero-when-released semantics are what the encoder's edge detection relies on.

## Interface

Parameters:
- `SCAN_CYCLES`, 50_000: clock cycles each row is driven low. Must be ≥ 3.
- `DEBOUNCE_FRAMES`, 20: consecutive identical frames required before `onehot` updates. Must be ≥ 1.

Ports:
- `clk` input 1: system clock, 50 MHz.
- `RSTn` input 1: reset, asynchronous and active-low.
- `col` input 4: keypad columns, active-low with external pull-ups, asynchronous to `clk`.
- `row` output 4: keypad row drive, active-low, exactly one row low during a scan slot.
- `onehot` output 16: debounced one-hot key code, `16'h0000` means no key.
- `key_strobe` output 1: one-cycle pulse when `onehot` takes a new non-zero value.

## Operation

**Column sampling**
- `col` passes through a 2-flop synchronizer before any use.

**State machine**
- States: ROW0, ROW1, ROW2, ROW3, EVAL.
- `row` is decoded from state: ROW0→`1110`, ROW1→`1101`, ROW2→`1011`, ROW3→`0111`, EVAL→`1111`.
- Each ROWn lasts `SCAN_CYCLES` cycles, counted by `slot_cnt` from 0 to `SCAN_CYCLES-1`.
- At `slot_cnt==SCAN_CYCLES-1`, the synchronized column bits are inverted and written to `frame[n*4+3:n*4]`. Then the FSM advances to the next row; after ROW3 it goes to EVAL.
- EVAL lasts exactly 1 cycle, then returns to ROW0 with `frame` cleared.

**Frame classification (in EVAL)**
- Zero bits set in `frame`: candidate = `16'h0000`.
- Exactly one bit set: candidate = `frame`.
- Two or more bits set (multi-key or ghosting): candidate = `16'h0000`.

**Debounce (in EVAL)**
- If candidate equals `last_cand`: `stable_cnt` increments, saturating at `DEBOUNCE_FRAMES`.
- Otherwise: `last_cand` is set to candidate and `stable_cnt` to 1.
- When the updated `stable_cnt` equals `DEBOUNCE_FRAMES` and candidate differs from `onehot`: `onehot` is set to candidate.
- If that new value is non-zero, `key_strobe` is 1 for that same update.
- `onehot` never changes outside EVAL.

**Key changes**
- A key-to-key change without an intervening release updates `onehot` directly to the new code.
- That update also pulses `key_strobe`.

## Timing

**Reset values**
- State ROW0, so `row=4'b1110`.
- `slot_cnt=0`, `frame=0`, `last_cand=0`, `stable_cnt=0`.
- `onehot=16'h0000`, `key_strobe=0`.
- Synchronizer flops reset to `4'b1111`.

**Frame timing**
- Frame period is `4*SCAN_CYCLES+1` cycles.
- All outputs are registered. `onehot` and `key_strobe` change on the clock edge that ends EVAL.
- Press-to-output latency is between `DEBOUNCE_FRAMES` and `DEBOUNCE_FRAMES+1` frames, plus 2 synchronizer cycles.
- Release latency is the same.

**Key width**
- `key_strobe` is high for exactly 1 cycle per accepted press.
- It is never high when `onehot` goes to 0.

**Boundary conditions**
- `SCAN_CYCLES ≥ 3`: the synchronizer delay settles inside the slot.
- Reset mid-frame: all state returns to reset values immediately and asynchronously. Debounce restarts from scratch.
- A key held through reset re-appears only after a full `DEBOUNCE_FRAMES` count.
- A held key never re-strobes. A saturated `stable_cnt` holds, with no wrap-around.

## Structure

- Package `keypad_pkg`: the state enum `kp_state_t` (ROW0..ROW3, EVAL), `KP_ROWS=4`, `KP_COLS=4`, `KP_NO_KEY=16'h0000`.
- Sub-module `sync2`: a 2-flop synchronizer with width parameter, async active-low reset, reset value all-ones. It is instantiated once for `col`.
- The one-bit-set check is a local function.

## Test plan

Bench parameters: `SCAN_CYCLES=4`, `DEBOUNCE_FRAMES=3`, giving a frame of 17 cycles.

1. **Reset and idle scan.** Hold `RSTn` low, then release.
   - During reset: `onehot=0000`, `key_strobe=0`, `row=1110`.
   - After release: `row` cycles 1110×4, 1101×4, 1011×4, 0111×4, 1111×1, period 17, with no strobe.
2. **Single press and release.** Hold `col[2]` low while `row[1]` is low (key 6) for 5 frames.
   - `onehot=16'h0040` after the 3rd complete frame, with a single 1-cycle `key_strobe`.
   - After release, `onehot=0000` after 3 frames, with no strobe.
3. **Bounce.** Toggle key 6 every 5 cycles for 2 frames, then hold it steady.
   - `onehot` stays `0000` until 3 consecutive clean frames, then becomes `0040`.
4. **Multi-key.** Press key 0 and key 5 together for 6 frames.
   - `onehot` stays `0000` and `key_strobe` never asserts.
5. **Reset mid-press.** With `onehot=0040`, pulse `RSTn` low for 2 cycles while the key stays held.
   - `onehot=0000` immediately and `row=1110`.
   - `0040` returns only after 3 full frames, with a fresh strobe.
6. **Key-to-key change.** Move from key 3 (`0008`) to key 15 (`8000`) without releasing.
   - `onehot` goes `0008`→`8000` after 3 frames of key 15, with one strobe and no intermediate `0000`.
